// File: rtl/skew_accumulator.sv
// Deskews systolic-array wavefronts into an N x N result matrix, accumulating
// across commands, and optionally streams the matrix out row by row.
module skew_accumulator #(
  parameter int ARRAY_DIM    = 8,
  parameter int PE_OUT_WIDTH = 32,
  parameter int ACC_WIDTH    = 40
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              start,
  input  logic                              clear,
  input  logic                              drain,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [ARRAY_DIM*PE_OUT_WIDTH-1:0] in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [ARRAY_DIM*ACC_WIDTH-1:0]    out_data,
  output logic [$clog2(ARRAY_DIM)-1:0]      out_row,
  output logic                              out_last,
  output logic                              busy,
  output logic                              done
);

  localparam int ROW_W  = $clog2(ARRAY_DIM);
  localparam int BEAT_W = $clog2(2*ARRAY_DIM-1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(2*ARRAY_DIM-2);
  localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ARRAY_DIM-1);

  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN} state_t;

  state_t                        r_state;
  state_t                        w_next;
  logic [BEAT_W-1:0]             r_beat;
  logic [ROW_W-1:0]              r_row;
  logic                          r_drain;
  logic                          r_done;
  logic signed [ACC_WIDTH-1:0]   r_acc [ARRAY_DIM][ARRAY_DIM];
  logic signed [PE_OUT_WIDTH-1:0] w_col [ARRAY_DIM];
  logic [ARRAY_DIM*ACC_WIDTH-1:0] w_out_data;
  logic                          w_beat_fire;
  logic                          w_out_fire;

  // Sign-extend the PE result and add with two's-complement wrap (no saturation).
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(
    input logic signed [ACC_WIDTH-1:0]    a,
    input logic signed [PE_OUT_WIDTH-1:0] b
  );
    logic signed [ACC_WIDTH-1:0] b_ext;
    b_ext = ACC_WIDTH'(b);
    return a + b_ext;
  endfunction

  always_comb begin
    for (int j = 0; j < ARRAY_DIM; j++) begin
      w_col[j] = in_data[j*PE_OUT_WIDTH +: PE_OUT_WIDTH];
    end
  end

  assign w_beat_fire = in_valid && (r_state == COLLECT);
  assign w_out_fire  = out_ready && (r_state == DRAIN);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next = COLLECT;
        end
      end
      COLLECT: begin
        if (w_beat_fire && (r_beat == LAST_BEAT)) begin
          w_next = r_drain ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (w_out_fire && (r_row == LAST_ROW)) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat k lands column j on row k-j; cells off the anti-diagonal are untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_beat  <= '0;
      r_row   <= '0;
      r_drain <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < ARRAY_DIM; i++) begin
        for (int j = 0; j < ARRAY_DIM; j++) begin
          r_acc[i][j] <= '0;
        end
      end
    end else begin
      r_done <= (r_state != IDLE) && (w_next == IDLE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_drain <= drain;
            r_beat  <= '0;
            r_row   <= '0;
            if (clear) begin
              for (int i = 0; i < ARRAY_DIM; i++) begin
                for (int j = 0; j < ARRAY_DIM; j++) begin
                  r_acc[i][j] <= '0;
                end
              end
            end
          end
        end
        COLLECT: begin
          if (w_beat_fire) begin
            for (int i = 0; i < ARRAY_DIM; i++) begin
              for (int j = 0; j < ARRAY_DIM; j++) begin
                if (int'(r_beat) == i + j) begin
                  r_acc[i][j] <= wrap_add(r_acc[i][j], w_col[j]);
                end
              end
            end
            r_beat <= r_beat + BEAT_W'(1);
          end
        end
        DRAIN: begin
          if (w_out_fire) begin
            r_row <= (r_row == LAST_ROW) ? '0 : r_row + ROW_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_out_data = '0;
    for (int j = 0; j < ARRAY_DIM; j++) begin
      w_out_data[j*ACC_WIDTH +: ACC_WIDTH] = r_acc[r_row][j];
    end
  end

  assign in_ready  = (r_state == COLLECT);
  assign out_valid = (r_state == DRAIN);
  assign out_data  = w_out_data;
  assign out_row   = r_row;
  assign out_last  = (r_state == DRAIN) && (r_row == LAST_ROW);
  assign busy      = (r_state != IDLE);
  assign done      = r_done;

endmodule

// File: tb/tb_skew_accumulator.sv
// Randomized scoreboard bench for skew_accumulator (N=4, 8-bit PE, 12-bit acc).
module tb_skew_accumulator;
  localparam int N  = 4;
  localparam int PW = 8;
  localparam int AW = 12;
  localparam int RW = 2;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            start = 1'b0, clear = 1'b0, drain = 1'b0;
  logic            in_valid = 1'b0, out_ready = 1'b0;
  logic [N*PW-1:0] in_data = '0;
  logic            in_ready, out_valid, out_last, busy, done;
  logic [N*AW-1:0] out_data;
  logic [RW-1:0]   out_row;

  skew_accumulator #(.ARRAY_DIM(N), .PE_OUT_WIDTH(PW), .ACC_WIDTH(AW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .clear(clear), .drain(drain),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int model [N][N];

  typedef struct {
    int              row;
    logic [N*AW-1:0] data;
    bit              last;
  } exp_t;
  exp_t expq[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expected rows on handshakes, checks stability while stalled.
  logic            stall_prev = 1'b0;
  logic [N*AW-1:0] prev_data;
  logic [RW-1:0]   prev_row;
  always @(negedge clk) begin
    if (!reset_n) begin
      stall_prev = 1'b0;
    end else if (out_valid) begin
      if (stall_prev) begin
        chk("stall_data", out_data, prev_data);
        chk("stall_row", out_row, prev_row);
      end
      if (out_ready) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_row actual=%0d required=none", out_row);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("row_idx", out_row, e.row);
          chk("row_data", out_data, e.data);
          chk("row_last", out_last, e.last);
        end
        stall_prev = 1'b0;
      end else begin
        stall_prev = 1'b1;
        prev_data  = out_data;
        prev_row   = out_row;
      end
    end else begin
      if (stall_prev) chk("stall_valid", out_valid, 1'b1);
      stall_prev = 1'b0;
    end
  end

  task automatic zero_model();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++)
        model[r][c] = 0;
  endtask

  task automatic push_rows();
    for (int r = 0; r < N; r++) begin
      exp_t e;
      e.row  = r;
      e.last = (r == N-1);
      for (int c = 0; c < N; c++) e.data[c*AW +: AW] = AW'(model[r][c] & 'hFFF);
      expq.push_back(e);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_row", out_row, 0);
  endtask

  task automatic do_abort();
    reset_n = 1'b0;
    #1;
    check_reset_outputs();
    zero_model();
    expq.delete();
    in_valid = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      chk("no_done_after_abort", done, 0);
    end
  endtask

  // mode: 0 = every column cval, 1 = beat k carries k+1, 2 = random bytes
  // rmode: 0 = always ready, 1 = random ready, 2 = hold row 1 for 3 cycles
  task automatic run_cmd(input bit c, input bit dr, input int mode, input int cval,
                         input int rmode, input int abort_at);
    int   guard;
    int   stall_cnt;
    bit   fin, last_acc;
    logic [PW-1:0] b;
    logic signed [PW-1:0] sb;
    guard = 0;
    while (busy && guard < 50) begin tick(); guard++; end
    chk("idle_before_start", busy, 0);
    start = 1'b1; clear = c; drain = dr;
    tick();
    start = 1'b0; clear = 1'b0; drain = 1'b0;
    if (c) zero_model();
    chk("busy_collect", busy, 1);
    for (int k = 0; k < 2*N-1; k++) begin
      if (abort_at == k) begin
        do_abort();
        return;
      end
      repeat ($urandom_range(0, 2)) begin
        in_valid = 1'b0;
        start = 1'($urandom % 2);
        clear = 1'b1;
        tick();
      end
      start = 1'b0; clear = 1'b0;
      chk("in_ready", in_ready, 1);
      for (int j = 0; j < N; j++) begin
        case (mode)
          0:       b = cval[PW-1:0];
          1:       b = PW'(k + 1);
          default: b = PW'($urandom);
        endcase
        in_data[j*PW +: PW] = b;
        sb = b;
        if ((k - j) >= 0 && (k - j) < N) model[k-j][j] += int'(sb);
      end
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
    end
    if (!dr) begin
      chk("done_collect", done, 1);
      chk("busy_after_collect", busy, 0);
      chk("no_out_valid", out_valid, 0);
      tick();
      chk("done_pulse_end", done, 0);
    end else begin
      push_rows();
      chk("out_valid_first", out_valid, 1);
      chk("out_row_first", out_row, 0);
      stall_cnt = 0; guard = 0; fin = 0;
      while (!fin && guard < 100) begin
        case (rmode)
          0: out_ready = 1'b1;
          1: out_ready = 1'($urandom % 2);
          default: begin
            if (out_row == 1 && stall_cnt < 3) begin
              out_ready = 1'b0;
              stall_cnt++;
            end else out_ready = 1'b1;
          end
        endcase
        in_valid = 1'($urandom % 2);
        in_data  = $urandom;
        last_acc = out_valid && out_ready && (out_row == RW'(N-1));
        tick();
        guard++;
        if (last_acc) fin = 1;
      end
      in_valid = 1'b0;
      out_ready = 1'b0;
      chk("drain_finished", fin, 1);
      chk("done_drain", done, 1);
      chk("out_valid_off", out_valid, 0);
      chk("busy_after_drain", busy, 0);
      if (rmode == 2) chk("stall_cycles", stall_cnt, 3);
      tick();
      chk("done_pulse_end", done, 0);
      chk("rows_all_delivered", expq.size(), 0);
    end
  endtask

  initial begin
    zero_model();
    #12;
    check_reset_outputs();
    reset_n = 1'b1;
    tick();

    run_cmd(1, 1, 0, 1, 0, -1);
    run_cmd(1, 1, 1, 0, 0, -1);
    run_cmd(1, 0, 0, 5, 0, -1);
    chk("busy_between_cmds", busy, 0);
    run_cmd(0, 1, 0, 5, 0, -1);
    run_cmd(1, 1, 2, 0, 2, -1);

    run_cmd(1, 0, 0, 127, 0, -1);
    for (int n = 0; n < 38; n++) run_cmd(0, 0, 0, 127, 0, -1);
    run_cmd(0, 1, 0, 127, 1, -1);
    run_cmd(1, 1, 0, -128, 0, -1);
    run_cmd(0, 1, 2, 0, 1, -1);

    run_cmd(1, 1, 1, 0, 0, 4);
    run_cmd(0, 1, 1, 0, 0, -1);
    run_cmd(1, 1, 2, 0, 1, -1);
    run_cmd(0, 1, 2, 0, 2, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
